// File: rtl/sha256_arbiter.sv
// sha256_arbiter: shares one sha256_core among NUM_REQ requesters.
// Define SHA256_ARB_FIXED_PRIORITY_EN for fixed priority instead of round-robin.
module sha256_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [512*NUM_REQ-1:0] req_block,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_id,
    output logic [255:0]           resp_hash,
    output logic [511:0]           core_block,
    output logic                   core_start,
    input  logic [255:0]           core_hash,
    input  logic                   core_ready,
    output logic                   busy,
    output logic [15:0]            blocks_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] win;
    logic [1:0] cur_id;
    logic       grant;

`ifdef SHA256_ARB_FIXED_PRIORITY_EN
    // Lowest-index valid requester always wins
    always_comb begin
        win = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win = 2'(k);
            end
        end
    end
`else
    logic [1:0] rr_ptr;
    int         rr_idx;
    logic       rr_found;

    // Round-robin search beginning at rr_ptr
    always_comb begin
        win      = 2'd0;
        rr_idx   = 0;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = int'(rr_ptr) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!rr_found && req_valid[rr_idx]) begin
                win      = 2'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    // Pointer moves just past each winner; holds when nothing is granted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (grant) begin
            if (int'(win) == NUM_REQ - 1) begin
                rr_ptr <= 2'd0;
            end else begin
                rr_ptr <= win + 2'd1;
            end
        end
    end
`endif

    // A grant only happens from IDLE with an idle core and a live request
    assign grant = rst_n && (state == IDLE) && core_ready && (|req_valid);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!core_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Decoded outputs: one-hot grant, start pulse, busy flag
    always_comb begin
        req_ready  = '0;
        core_start = 1'b0;
        busy       = 1'b0;
        if (grant) begin
            req_ready = NUM_REQ'(1) << win;
        end
        if (state == ISSUE) begin
            core_start = 1'b1;
        end
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

    // Block capture, response registers and completion counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_block  <= '0;
            cur_id      <= 2'd0;
            resp_valid  <= 1'b0;
            resp_id     <= 2'd0;
            resp_hash   <= '0;
            blocks_done <= 16'd0;
        end else begin
            if (grant) begin
                core_block <= req_block[int'(win)*512 +: 512];
                cur_id     <= win;
            end
            if (state == WAIT_DONE && core_ready) begin
                resp_valid <= 1'b1;
                resp_id    <= cur_id;
                resp_hash  <= core_hash;
            end
            if (state == RESP && resp_ready) begin
                resp_valid  <= 1'b0;
                blocks_done <= blocks_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha256_arbiter.sv
// tb_sha256_arbiter: directed stimulus with a queued scoreboard.
// A small core model answers known padded blocks with their SHA-256 digests.
module tb_sha256_arbiter;

    localparam int N = 4;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
    localparam logic [511:0] BLK_TEST  = {40'h7465737480, 408'h0, 64'h20};

    localparam logic [255:0] H_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] H_TEST =
        256'h9f86d081884c7d659a2feaa0c55ad015a3bf4f1b2b0b822cd15d6c15b0f00a08;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [512*N-1:0] req_block;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [255:0]     resp_hash;
    logic [511:0]     core_block;
    logic             core_start;
    logic [255:0]     core_hash = '0;
    logic             core_ready = 1'b1;
    logic             busy;
    logic [15:0]      blocks_done;

    typedef struct packed {
        logic [1:0]   id;
        logic [255:0] hash;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    logic [15:0] exp_done = 16'd0;
    bit         skip_done = 1'b0;
    bit         hold = 1'b0;
    int         lat = 0;

    always #5 clk = ~clk;

    sha256_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_block   (req_block),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_hash   (resp_hash),
        .core_block  (core_block),
        .core_start  (core_start),
        .core_hash   (core_hash),
        .core_ready  (core_ready),
        .busy        (busy),
        .blocks_done (blocks_done)
    );

    function automatic logic [255:0] mock_hash(input logic [511:0] b);
        if (b == BLK_ABC)   return H_ABC;
        if (b == BLK_EMPTY) return H_EMPTY;
        if (b == BLK_TEST)  return H_TEST;
        return b[511:256];
    endfunction

    // Core model: drops ready for a few cycles after each start
    always @(posedge clk) begin
        if (core_start && core_ready) begin
            core_ready <= 1'b0;
            lat        <= 4;
        end else if (!core_ready) begin
            if (lat == 0) begin
                core_ready <= 1'b1;
                core_hash  <= mock_hash(core_block);
            end else begin
                lat <= lat - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: one-hot grants and response scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done = 16'd0;
        end else begin
            if (req_ready != '0) begin
                chk("grant_onehot", 256'($countones(req_ready)), 256'd1);
            end
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_id", 256'(resp_id), 256'(e.id));
                    chk("resp_hash", resp_hash, e.hash);
                    if (!skip_done) begin
                        chk("blocks_done", 256'(blocks_done), 256'(exp_done));
                    end
                    exp_done = exp_done + 16'd1;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [511:0] blk);
        req_block[512*i +: 512] = blk;
        req_valid[i] = 1'b1;
    endtask

    task automatic push(input logic [1:0] id, input logic [255:0] h);
        exp_t e;
        e.id   = id;
        e.hash = h;
        q.push_back(e);
    endtask

    // One clock: sample grants at negedge, drive inputs after posedge
    task automatic cyc(output int n);
        logic [N-1:0] g;
        @(negedge clk);
        g = req_ready;
        n = $countones(g);
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = req_valid & ~g;
        end
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            cyc(n);
            if (q.size() == 0 && req_valid == '0 && !busy) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            fail_now({"timeout_", name});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 256'(req_ready), 256'd0);
        chk({tag, "_resp_valid"}, 256'(resp_valid), 256'd0);
        chk({tag, "_resp_id"}, 256'(resp_id), 256'd0);
        chk({tag, "_resp_hash"}, resp_hash, 256'd0);
        chk({tag, "_core_block"}, core_block[511:256] | core_block[255:0],
            256'd0);
        chk({tag, "_core_start"}, 256'(core_start), 256'd0);
        chk({tag, "_busy"}, 256'(busy), 256'd0);
        chk({tag, "_blocks_done"}, 256'(blocks_done), 256'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        bit seen;
        logic [1:0]   id0;
        logic [255:0] h0;
        logic [15:0]  d0;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_block  = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;

        // Two simultaneous requests after reset: 0 first, then 3
        set_req(0, BLK_EMPTY);
        set_req(3, BLK_ABC);
        push(2'd0, H_EMPTY);
        push(2'd3, H_ABC);
        run_until_idle("pair", 200);

        // All four held for eight grants
        for (int i = 0; i < N; i++) begin
            req_block[512*i +: 512] = {32'hC0DE0000 + 32'(i), 480'h0};
        end
        for (int k = 0; k < 8; k++) begin
`ifdef SHA256_ARB_FIXED_PRIORITY_EN
            push(2'd0, {32'hC0DE0000, 224'h0});
`else
            push(2'(k % 4), {32'hC0DE0000 + 32'(k % 4), 224'h0});
`endif
        end
        hold = 1'b1;
        req_valid = '1;
        g = 0;
        for (int c = 0; c < 400 && g < 8; c++) begin
            cyc(n);
            g += n;
        end
        req_valid = '0;
        hold = 1'b0;
        chk("rr_grant_count", 256'(g), 256'd8);
        run_until_idle("rr", 200);

        // Single "abc" request from requester 2
        set_req(2, BLK_ABC);
        push(2'd2, H_ABC);
        run_until_idle("abc", 200);

        // Response held off for 20 cycles while another request waits
        resp_ready = 1'b0;
        set_req(1, BLK_EMPTY);
        push(2'd1, H_EMPTY);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            cyc(n);
            seen = resp_valid;
        end
        if (!seen) begin
            fail_now("timeout_stall_resp");
        end
        id0 = resp_id;
        h0  = resp_hash;
        d0  = blocks_done;
        set_req(3, BLK_ABC);
        push(2'd3, H_ABC);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0 || c == 19) begin
                chk("stall_valid", 256'(resp_valid), 256'd1);
                chk("stall_id", 256'(resp_id), 256'(id0));
                chk("stall_hash", resp_hash, h0);
            end
            if (req_ready != '0) begin
                fail_now("stall_grant");
            end
            if (resp_valid !== 1'b1 || resp_hash !== h0) begin
                fail_now("stall_unstable");
            end
            @(posedge clk);
            #1;
        end
        chk("stall_done_held", 256'(blocks_done), 256'(d0));
        resp_ready = 1'b1;
        cyc(n);
        chk("stall_done_inc", 256'(blocks_done), 256'(d0 + 16'd1));
        run_until_idle("stall", 200);

        // Reset while waiting on the core; result must vanish
        set_req(0, BLK_ABC);
        push(2'd0, H_ABC);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            cyc(n);
            seen = busy && !core_ready && !core_start;
        end
        if (!seen) begin
            fail_now("timeout_reach_wait");
        end
        cyc(n);
        rst_n = 1'b0;
        void'(q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        @(posedge clk);
        #1;
        set_req(1, BLK_TEST);
        push(2'd1, H_TEST);
        run_until_idle("after_reset", 200);

        // Counter wrap from 0xFFFF
        skip_done = 1'b1;
        @(negedge clk);
        force dut.blocks_done = 16'hFFFF;
        #1;
        release dut.blocks_done;
        chk("preload", 256'(blocks_done), 256'hFFFF);
        @(posedge clk);
        #1;
        set_req(2, BLK_EMPTY);
        push(2'd2, H_EMPTY);
        run_until_idle("wrap", 200);
        chk("wrap", 256'(blocks_done), 256'h0);

        chk("queue_empty", 256'(q.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
